codificador_imm: RTL

Streaming RV64 instruction encoder: the inverse of the immediate generator. Accepts decoded fields (format, registers, funct3, 64-bit sign-extended immediate), repacks the immediate into its scattered instruction bit positions, and writes the resulting 32-bit words sequentially into instruction memory. Used by the test/boot loader path to build programs in on-chip memory without a host assembler. Supports the same three formats as the decode side: load (I), store (S) and branch (B).

---
 rtl/riscv_pkg.sv | 40 ++++
 rtl/empaqueta_imm.sv | 67 ++++++
 rtl/codificador_imm.sv | 118 +++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg
// Shared definitions for the RV64 load/store/branch encoder path.
//   - Opcode constants for the three supported formats.
//   - tipo_t: format selector carried on the encoder's `tipo` input.
//   - estado_t: encoder FSM states (also exported on the debug port).
//   - todos_iguales: helper that tests whether an immediate is a pure sign
//     extension above a given bit (used by the optional range check).
package riscv_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        TIPO_I   = 2'b00,
        TIPO_S   = 2'b01,
        TIPO_B   = 2'b10,
        TIPO_INV = 2'b11
    } tipo_t;

    typedef enum logic [1:0] {
        ACTIVO = 2'b00,
        LLENO  = 2'b01,
        ERROR  = 2'b10
    } estado_t;

    // True when inmediato[63:msb] are all the same bit, i.e. the value fits
    // in a signed field whose sign bit is `msb`.
    function automatic logic todos_iguales(input logic [63:0] imm, input int msb);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 64; i++) begin
            if (i >= msb && imm[i] != imm[63]) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/empaqueta_imm.sv
// empaqueta_imm
// Purely combinational format packer: takes decoded fields and scatters the
// immediate into its instruction bit positions for I (load), S (store) and
// B (branch) encodings.
//
// Ports:
//   tipo       in  2   format selector (riscv_pkg::tipo_t encoding)
//   rd/rs1/rs2 in  5   register indices (unused ones are ignored)
//   funct3     in  3   copied to bits [14:12]
//   inmediato  in  64  sign-extended immediate (byte offset for B)
//   palabra    out 32  encoded instruction word
//   valido     out 1   bundle may be written (format legal, range ok)
//
// Configuration: CODIFICADOR_RANGO_EN enables the immediate range check.
// Without it the immediate is simply truncated to the field bits.
import riscv_pkg::*;

module empaqueta_imm (
    input  logic [1:0]  tipo,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [63:0] inmediato,
    output logic [31:0] palabra,
    output logic        valido
);

    tipo_t t;
    logic  rango_ok;

    assign t = tipo_t'(tipo);

`ifdef CODIFICADOR_RANGO_EN
    // With the check on, a legal immediate has inmediato[11] (I/S) or
    // inmediato[12] (B) equal to inmediato[63], so the sign bit in inst[31]
    // is the same whichever of them is picked.
    always_comb begin
        rango_ok = 1'b0;
        case (t)
            TIPO_I, TIPO_S: rango_ok = todos_iguales(inmediato, 11);
            TIPO_B:         rango_ok = todos_iguales(inmediato, 12) && !inmediato[0];
            default:        rango_ok = 1'b0;
        endcase
    end
`else
    // No range check: upper immediate bits are intentionally dropped.
    logic unused_imm_alto;
    assign unused_imm_alto = ^inmediato[63:13];
    assign rango_ok        = 1'b1;
`endif

    always_comb begin
        palabra = 32'h0;
        case (t)
            TIPO_I: palabra = {inmediato[11:0], rs1, funct3, rd, OP_LOAD};
            TIPO_S: palabra = {inmediato[11:5], rs2, rs1, funct3,
                               inmediato[4:0], OP_STORE};
            TIPO_B: palabra = {inmediato[12], inmediato[10:5], rs2, rs1, funct3,
                               inmediato[4:1], inmediato[11], OP_BRANCH};
            default: palabra = 32'h0;
        endcase
    end

    assign valido = (t != TIPO_INV) && rango_ok;

endmodule

// File: rtl/codificador_imm.sv
// codificador_imm
// Streaming RV64 instruction encoder. Accepts decoded field bundles, packs
// them into 32-bit instructions (via empaqueta_imm) and writes them to
// consecutive instruction-memory words starting at address 0.
//
// Handshake: a bundle transfers on a rising edge where in_valid && in_ready.
// in_ready is combinational: high only in ACTIVO, with limpiar and reset low.
// in_valid may be held or dropped freely; nothing is buffered.
//
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   limpiar        synchronous restart (pointer/count/error/full cleared)
//   in_valid       bundle valid
//   in_ready       encoder accepts this cycle
//   tipo           format: 00 I, 01 S, 10 B, 11 invalid
//   rd, rs1, rs2   register indices
//   funct3         function field
//   inmediato      64-bit sign-extended immediate
//   wr_en          one-cycle memory write strobe
//   wr_addr        word address of wr_data
//   wr_data        encoded instruction (holds when wr_en is low)
//   cuenta         words written since reset/limpiar
//   lleno          cuenta == PROF
//   error          sticky: a bundle was rejected
//   estado         current FSM state (debug)
//
// Configuration: define CODIFICADOR_RANGO_EN to reject immediates that do
// not fit their format field.
import riscv_pkg::*;

module codificador_imm #(
    parameter int ADDR_W = 8,
    parameter int PROF   = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              limpiar,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        tipo,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        funct3,
    input  logic [63:0]       inmediato,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic [ADDR_W:0]   cuenta,
    output logic              lleno,
    output logic              error,
    output logic [1:0]        estado
);

    localparam logic [ADDR_W:0] PROF_C = PROF[ADDR_W:0];

    estado_t          st;
    logic [31:0]      palabra;
    logic             valido;
    logic             acepta;
    logic [ADDR_W:0]  cuenta_sig;

    empaqueta_imm u_empaqueta (
        .tipo      (tipo),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .funct3    (funct3),
        .inmediato (inmediato),
        .palabra   (palabra),
        .valido    (valido)
    );

    assign in_ready   = (st == ACTIVO) && !limpiar && !reset;
    assign acepta     = in_valid && in_ready;
    assign cuenta_sig = cuenta + 1'b1;
    assign estado     = st;

    // The write pointer is the low part of cuenta: words are written densely
    // from address 0, so the count of words written is the next address.
    always_ff @(posedge clk) begin
        if (reset) begin
            st      <= ACTIVO;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= 32'h0;
            cuenta  <= '0;
            lleno   <= 1'b0;
            error   <= 1'b0;
        end else begin
            // Strobe lasts exactly one cycle. A write registered in the
            // previous cycle is already on the outputs, so limpiar here
            // cannot cancel it.
            wr_en <= 1'b0;
            if (limpiar) begin
                st     <= ACTIVO;
                cuenta <= '0;
                lleno  <= 1'b0;
                error  <= 1'b0;
            end else if (acepta) begin
                if (valido) begin
                    wr_en   <= 1'b1;
                    wr_addr <= cuenta[ADDR_W-1:0];
                    wr_data <= palabra;
                    cuenta  <= cuenta_sig;
                    if (cuenta_sig == PROF_C) begin
                        lleno <= 1'b1;
                        st    <= LLENO;
                    end
                end else begin
                    error <= 1'b1;
                    st    <= ERROR;
                end
            end
        end
    end

endmodule
